// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register file geometry, hazard FSM states,
// writeback latencies and the zeroed ID/EX control bundle.
package pipe_pkg;
   localparam int REG_W    = 3;
   localparam int NREG     = 1 << REG_W;
   localparam int ALU_LAT  = 2;
   localparam int LOAD_LAT = 3;
   localparam int SB_W     = 2;

   typedef enum logic [1:0] {RUN, STALL, FLUSH} hz_state_t;

   typedef struct packed {
      logic       write_reg;
      logic       write_mem;
      logic       read_mem;
      logic [3:0] alu_op;
   } id_ex_ctrl_t;

   localparam id_ex_ctrl_t ctrl_bubble = '0;
endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage request and hazard-control response bundle between the pipeline
// (master) and the hazard controller (slave).
interface hazard_ctrl_if #(parameter int CNT_W = 16);
   import pipe_pkg::*;
   logic             id_valid;
   logic [REG_W-1:0] id_reg1;
   logic [REG_W-1:0] id_reg2;
   logic             id_uses_reg1;
   logic             id_uses_reg2;
   logic             id_write_reg;
   logic [REG_W-1:0] id_dest;
   logic             id_read_mem;
   logic             ex_taken;
   logic             stall_if;
   logic             bubble_ex;
   logic             flush_if_id;
   logic             issue;
   logic             sb_busy;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_valid, id_reg1, id_reg2, id_uses_reg1, id_uses_reg2,
             id_write_reg, id_dest, id_read_mem, ex_taken,
      input  stall_if, bubble_ex, flush_if_id, issue, sb_busy, stall_count
   );
   modport slave (
      input  id_valid, id_reg1, id_reg2, id_uses_reg1, id_uses_reg2,
             id_write_reg, id_dest, id_read_mem, ex_taken,
      output stall_if, bubble_ex, flush_if_id, issue, sb_busy, stall_count
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register countdown of cycles until a pending write is readable.
// A write to an entry overrides that entry's decrement in the same cycle.
module reg_scoreboard
   import pipe_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] rd_idx1,
   input  logic [REG_W-1:0] rd_idx2,
   input  logic             wr_en,
   input  logic [REG_W-1:0] wr_idx,
   input  logic [SB_W-1:0]  wr_val,
   output logic             busy1,
   output logic             busy2,
   output logic             any_busy
);
   logic [SB_W-1:0] sb [NREG];
   logic [NREG-1:0] nz;

   for (genvar r = 0; r < NREG; r++) begin : g_ent
      always_ff @(posedge clk) begin
         if (reset)                             sb[r] <= '0;
         else if (wr_en && wr_idx == REG_W'(r)) sb[r] <= wr_val;
         else if (sb[r] != '0)                  sb[r] <= sb[r] - SB_W'(1);
      end
      assign nz[r] = |sb[r];
   end

   assign busy1    = nz[rd_idx1];
   assign busy2    = nz[rd_idx2];
   assign any_busy = |nz;
endmodule

// File: rtl/hazard_ctrl.sv
// ID/EX hazard controller: RAW stall from the scoreboard, squash after a
// taken branch in EX, and a saturating count of stall cycles.
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic          clk,
   input  logic          reset,
   hazard_ctrl_if.slave  h
);
   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

   hz_state_t        state;
   logic [FC_W-1:0]  fcnt;
   logic [CNT_W-1:0] cnt;
   logic             busy1, busy2, any_busy, raw;
   logic             stall, bubble, flush, issue;
   logic [SB_W-1:0]  lat;

   assign lat = h.id_read_mem ? SB_W'(LOAD_LAT) : SB_W'(ALU_LAT);

   reg_scoreboard u_sb (
      .clk      (clk),
      .reset    (reset),
      .rd_idx1  (h.id_reg1),
      .rd_idx2  (h.id_reg2),
      .wr_en    (issue & h.id_write_reg),
      .wr_idx   (h.id_dest),
      .wr_val   (lat),
      .busy1    (busy1),
      .busy2    (busy2),
      .any_busy (any_busy)
   );

   assign raw = h.id_valid & ((h.id_uses_reg1 & busy1) | (h.id_uses_reg2 & busy2));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         fcnt  <= '0;
      end else begin
         case (state)
            RUN, STALL: begin
               if (h.ex_taken && FLUSH_CYCLES > 0) begin
                  state <= FLUSH;
                  fcnt  <= FC_W'(FLUSH_CYCLES);
               end else if (h.ex_taken) state <= RUN;
               else                     state <= raw ? STALL : RUN;
            end
            FLUSH: begin
               if (h.ex_taken) fcnt <= FC_W'(FLUSH_CYCLES);
               else if (fcnt <= FC_W'(1)) begin
                  state <= RUN;
                  fcnt  <= '0;
               end else fcnt <= fcnt - FC_W'(1);
            end
            default: state <= RUN;
         endcase
      end
   end

   // Taken branch outranks everything: the ID instruction is wrong-path.
   always_comb begin
      stall  = 1'b0;
      bubble = 1'b0;
      flush  = 1'b0;
      issue  = 1'b0;
      if (!reset) begin
         if (h.ex_taken || state == FLUSH) begin
            flush  = 1'b1;
            bubble = 1'b1;
         end else if (raw) begin
            stall  = 1'b1;
            bubble = 1'b1;
         end else issue = h.id_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)                  cnt <= '0;
      else if (stall && cnt != '1) cnt <= cnt + CNT_W'(1);
   end

   assign h.stall_if    = stall;
   assign h.bubble_ex   = bubble;
   assign h.flush_if_id = flush;
   assign h.issue       = issue;
   assign h.sb_busy     = reset ? 1'b0 : any_busy;
   assign h.stall_count = reset ? '0 : cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a second instance with a 4-bit counter
// exercises stall_count saturation in a short run.
module tb_hazard_ctrl;
   import pipe_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic             id_valid, id_uses_reg1, id_uses_reg2, id_write_reg, id_read_mem, ex_taken;
   logic [REG_W-1:0] id_reg1, id_reg2, id_dest;

   hazard_ctrl_if #(.CNT_W(16)) hi ();
   hazard_ctrl_if #(.CNT_W(4))  hs ();

   assign hi.id_valid = id_valid;          assign hs.id_valid = id_valid;
   assign hi.id_reg1 = id_reg1;            assign hs.id_reg1 = id_reg1;
   assign hi.id_reg2 = id_reg2;            assign hs.id_reg2 = id_reg2;
   assign hi.id_uses_reg1 = id_uses_reg1;  assign hs.id_uses_reg1 = id_uses_reg1;
   assign hi.id_uses_reg2 = id_uses_reg2;  assign hs.id_uses_reg2 = id_uses_reg2;
   assign hi.id_write_reg = id_write_reg;  assign hs.id_write_reg = id_write_reg;
   assign hi.id_dest = id_dest;            assign hs.id_dest = id_dest;
   assign hi.id_read_mem = id_read_mem;    assign hs.id_read_mem = id_read_mem;
   assign hi.ex_taken = ex_taken;          assign hs.ex_taken = ex_taken;

   hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) dut   (.clk(clk), .reset(reset), .h(hi));
   hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4))  dut_s (.clk(clk), .reset(reset), .h(hs));

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [REG_W-1:0] r1, input logic u1,
                         input logic [REG_W-1:0] r2, input logic u2,
                         input logic wr, input logic [REG_W-1:0] d, input logic mem);
      id_valid = v; id_reg1 = r1; id_uses_reg1 = u1; id_reg2 = r2; id_uses_reg2 = u2;
      id_write_reg = wr; id_dest = d; id_read_mem = mem;
   endtask

   task automatic chk_o(input string tag, input logic s, input logic b, input logic f, input logic i);
      #1;
      chk({tag, ".stall"}, 32'(hi.stall_if), 32'(s));
      chk({tag, ".bubble"}, 32'(hi.bubble_ex), 32'(b));
      chk({tag, ".flush"}, 32'(hi.flush_if_id), 32'(f));
      chk({tag, ".issue"}, 32'(hi.issue), 32'(i));
   endtask

   task automatic idle(input int n);
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (n) cyc();
   endtask

   initial begin
      reset = 1'b1; ex_taken = 1'b0;
      set_id(1, 0, 0, 0, 0, 1, 0, 0);
      chk_o("rst_hold", 0, 0, 0, 0);
      cyc(); cyc();
      reset = 1'b0;
      idle(1);
      #1;
      chk("rst_busy", 32'(hi.sb_busy), 0);
      chk("rst_cnt", 32'(hi.stall_count), 0);

      // ALU write r3, dependent read via reg1 stalls 2 cycles
      set_id(1, 0, 0, 0, 0, 1, 3, 0); chk_o("alu_wr", 0, 0, 0, 1); cyc();
      set_id(1, 3, 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         chk_o("alu_dep_stall", 1, 1, 0, 0);
         chk("alu_busy", 32'(hi.sb_busy), 1);
         cyc();
      end
      chk_o("alu_dep_go", 0, 0, 0, 1);
      chk("alu_cnt", 32'(hi.stall_count), 2);
      idle(1);

      // Load r5, reader via reg2 stalls 3; reading r4 instead does not
      set_id(1, 0, 0, 0, 0, 1, 5, 1); chk_o("ld_wr", 0, 0, 0, 1); cyc();
      set_id(1, 0, 0, 5, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin chk_o("ld_dep_stall", 1, 1, 0, 0); cyc(); end
      chk_o("ld_dep_go", 0, 0, 0, 1);
      chk("ld_cnt", 32'(hi.stall_count), 5);
      cyc();
      set_id(1, 0, 0, 0, 0, 1, 5, 1); chk_o("ld_wr2", 0, 0, 0, 1); cyc();
      set_id(1, 0, 0, 4, 1, 0, 0, 0); chk_o("ld_indep", 0, 0, 0, 1);
      chk("ld_busy", 32'(hi.sb_busy), 1);
      idle(3);
      #1 chk("drain_busy", 32'(hi.sb_busy), 0);

      // Stall on r2 interrupted by a taken branch; squashed write to r7
      set_id(1, 0, 0, 0, 0, 1, 2, 0); chk_o("br_wr", 0, 0, 0, 1); cyc();
      set_id(1, 2, 1, 0, 0, 1, 7, 0); chk_o("br_stall", 1, 1, 0, 0); cyc();
      ex_taken = 1'b1;
      chk_o("br_taken", 0, 1, 1, 0);
      chk("br_taken_busy", 32'(hi.sb_busy), 1);
      cyc();
      ex_taken = 1'b0;
      #1;
      chk("br_flush.flush", 32'(hi.flush_if_id), 1);
      chk("br_flush.bubble", 32'(hi.bubble_ex), 1);
      chk("br_flush.issue", 32'(hi.issue), 0);
      chk("br_flush_busy", 32'(hi.sb_busy), 0);
      cyc();
      chk_o("br_run", 0, 0, 0, 1);
      chk("br_cnt", 32'(hi.stall_count), 6);
      idle(3);

      // Back-to-back ALU writes to r1: second reloads, reader stalls 2
      set_id(1, 0, 0, 0, 0, 1, 1, 0); chk_o("b2b_wr1", 0, 0, 0, 1); cyc();
      chk_o("b2b_wr2", 0, 0, 0, 1); cyc();
      set_id(1, 1, 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin chk_o("b2b_stall", 1, 1, 0, 0); cyc(); end
      chk_o("b2b_go", 0, 0, 0, 1);
      chk("b2b_cnt", 32'(hi.stall_count), 8);
      idle(3);

      // Reset in the middle of a stall on r6
      set_id(1, 0, 0, 0, 0, 1, 6, 0); chk_o("rs_wr", 0, 0, 0, 1); cyc();
      set_id(1, 6, 1, 0, 0, 0, 0, 0); chk_o("rs_stall", 1, 1, 0, 0);
      reset = 1'b1;
      chk_o("rs_in_reset", 0, 0, 0, 0);
      chk("rs_in_busy", 32'(hi.sb_busy), 0);
      chk("rs_in_cnt", 32'(hi.stall_count), 0);
      cyc();
      reset = 1'b0;
      chk_o("rs_after", 0, 0, 0, 1);
      chk("rs_after_busy", 32'(hi.sb_busy), 0);
      chk("rs_after_cnt", 32'(hi.stall_count), 0);
      idle(1);

      // Saturation: 5 loads give 15 stalls, a 6th must hold the 4-bit count at F
      for (int n = 1; n <= 6; n++) begin
         set_id(1, 0, 0, 0, 0, 1, 4, 1); chk_o("sat_wr", 0, 0, 0, 1); cyc();
         set_id(1, 4, 1, 0, 0, 0, 0, 0);
         for (int k = 0; k < 3; k++) begin chk_o("sat_stall", 1, 1, 0, 0); cyc(); end
         chk_o("sat_go", 0, 0, 0, 1);
         chk("sat_main_cnt", 32'(hi.stall_count), 32'(3 * n));
         chk("sat_small_cnt", 32'(hs.stall_count), (3 * n >= 15) ? 32'hF : 32'(3 * n));
         cyc();
      end
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
